// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and default sizing for the PWM dead-band inserter
package pwm_pkg;
  localparam int CH_NUM_DEF = 8;
  localparam int DT_W_DEF = 16;
  typedef enum logic [2:0] {S_OFF, S_LOW, S_DT_RISE, S_HIGH, S_DT_FALL} db_state_t;
endpackage

// File: rtl/pwm_db_chan.sv
// pwm_db_chan: one channel's dead-band FSM and counter with flop-driven gate outputs
// Ports: clk_i/rst_i clock and sync reset; pwm_i raw PWM; dt_i dead-time;
// off_i force OFF; go_i permits OFF->LOW; pol_i output inversion; h_o/l_o gate drives.
module pwm_db_chan import pwm_pkg::*; #(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pwm_i,
  input  logic [DT_W-1:0] dt_i,
  input  logic            off_i,
  input  logic            go_i,
  input  logic            pol_i,
  output logic            h_o,
  output logic            l_o
);
  db_state_t st_q, st_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic h_q, l_q;
  logic dz;
  assign dz = dt_i == '0;
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    if (off_i) begin
      st_d = S_OFF;
      cnt_d = '0;
    end else begin
      case (st_q)
        S_OFF: st_d = go_i ? S_LOW : S_OFF;
        S_LOW: if (pwm_i) begin
          st_d = dz ? S_HIGH : S_DT_RISE;
          cnt_d = dz ? '0 : dt_i - 1'b1;
        end
        S_DT_RISE: begin
          st_d = !pwm_i ? S_LOW : (cnt_q == '0) ? S_HIGH : S_DT_RISE;
          cnt_d = (pwm_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        end
        S_HIGH: if (!pwm_i) begin
          st_d = dz ? S_LOW : S_DT_FALL;
          cnt_d = dz ? '0 : dt_i - 1'b1;
        end
        S_DT_FALL: begin
          st_d = pwm_i ? S_HIGH : (cnt_q == '0) ? S_LOW : S_DT_FALL;
          cnt_d = (!pwm_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        end
        default: st_d = S_OFF;
      endcase
    end
  end
  // outputs are registered from the next state so the gate pins come straight off flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q <= S_OFF;
      cnt_q <= '0;
      h_q <= pol_i;
      l_q <= pol_i;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      h_q <= (st_d == S_HIGH) ^ pol_i;
      l_q <= (st_d == S_LOW) ^ pol_i;
    end
  end
  assign h_o = h_q;
  assign l_o = l_q;
endmodule

// File: rtl/pwm_deadband.sv
// pwm_deadband: multi-channel complementary gate driver with dead-time, enable and sticky fault
// Ports: CLK, RST (sync active-high); PWM_IN raw PWM; DEADTIME shared dead-time;
// OUT_EN enable; FAULT/FAULT_CLR fault set/clear; PWM_H/PWM_L gate drives; FAULT_FLAG sticky.
// Optional macro PWM_DEADBAND_POLARITY_EN adds POL_INV per-channel output inversion.
module pwm_deadband import pwm_pkg::*; #(
  parameter int CH_NUM = CH_NUM_DEF,
  parameter int DT_W = DT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CH_NUM-1:0] PWM_IN,
  input  logic [DT_W-1:0]   DEADTIME,
  input  logic              OUT_EN,
  input  logic              FAULT,
  input  logic              FAULT_CLR,
  output logic [CH_NUM-1:0] PWM_H,
  output logic [CH_NUM-1:0] PWM_L,
  output logic              FAULT_FLAG
`ifdef PWM_DEADBAND_POLARITY_EN
  ,
  input  logic [CH_NUM-1:0] POL_INV
`endif
);
  logic fault_flag_q;
  logic off;
  logic [CH_NUM-1:0] pol;
`ifdef PWM_DEADBAND_POLARITY_EN
  assign pol = POL_INV;
`else
  assign pol = '0;
`endif
  assign off = !OUT_EN || FAULT;
  always_ff @(posedge CLK) begin
    if (RST) fault_flag_q <= 1'b0;
    else if (FAULT) fault_flag_q <= 1'b1;
    else if (FAULT_CLR) fault_flag_q <= 1'b0;
  end
  assign FAULT_FLAG = fault_flag_q;
  // leaving OFF uses the flag as it stood before this edge, so a clear costs one extra cycle
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    pwm_db_chan #(.DT_W(DT_W)) u_chan (
      .clk_i(CLK),
      .rst_i(RST),
      .pwm_i(PWM_IN[i]),
      .dt_i(DEADTIME),
      .off_i(off),
      .go_i(!fault_flag_q),
      .pol_i(pol[i]),
      .h_o(PWM_H[i]),
      .l_o(PWM_L[i])
    );
  end
endmodule

// File: tb/tb_pwm_deadband.sv
// tb_pwm_deadband: directed scoreboard bench for pwm_deadband
module tb_pwm_deadband;
  localparam int CH = 8;
  localparam int DW = 16;
  logic CLK = 1'b0;
  logic RST, OUT_EN, FAULT, FAULT_CLR;
  logic [CH-1:0] PWM_IN, PWM_H, PWM_L;
  logic [DW-1:0] DEADTIME;
  logic FAULT_FLAG;
`ifdef PWM_DEADBAND_POLARITY_EN
  logic [CH-1:0] POL_INV = '0;
`endif
  int errors = 0;
  int checks = 0;
  typedef struct {
    string tag;
    logic [CH-1:0] h;
    logic [CH-1:0] l;
    logic f;
  } exp_t;
  exp_t sb[$];
  pwm_deadband #(.CH_NUM(CH), .DT_W(DW)) dut (
    .CLK(CLK),
    .RST(RST),
    .PWM_IN(PWM_IN),
    .DEADTIME(DEADTIME),
    .OUT_EN(OUT_EN),
    .FAULT(FAULT),
    .FAULT_CLR(FAULT_CLR),
    .PWM_H(PWM_H),
    .PWM_L(PWM_L),
    .FAULT_FLAG(FAULT_FLAG)
`ifdef PWM_DEADBAND_POLARITY_EN
    ,
    .POL_INV(POL_INV)
`endif
  );
  always #5 CLK = ~CLK;
  task automatic cycv(input string tag, input logic [CH-1:0] h, input logic [CH-1:0] l, input logic f);
    exp_t e;
    sb.push_back('{tag, h, l, f});
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    checks++;
    assert (PWM_H === e.h) else begin errors++; $error("FAIL %s PWM_H got %h exp %h", e.tag, PWM_H, e.h); end
    checks++;
    assert (PWM_L === e.l) else begin errors++; $error("FAIL %s PWM_L got %h exp %h", e.tag, PWM_L, e.l); end
    checks++;
    assert (FAULT_FLAG === e.f) else begin errors++; $error("FAIL %s FAULT_FLAG got %b exp %b", e.tag, FAULT_FLAG, e.f); end
  endtask
  task automatic cyc(input string tag, input logic h, input logic l, input logic f);
    cycv(tag, {CH{h}}, {CH{l}}, f);
  endtask
  task automatic gap(input string tag, input int n);
    for (int k = 0; k < n; k++) cyc(tag, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    RST = 1'b1; OUT_EN = 1'b0; FAULT = 1'b0; FAULT_CLR = 1'b0; PWM_IN = '0; DEADTIME = 16'd5;
    cyc("reset", 0, 0, 0);
    cyc("reset_hold", 0, 0, 0);
    RST = 1'b0; OUT_EN = 1'b1;
    cyc("enable_low", 0, 1, 0);
    cyc("low_idle", 0, 1, 0);
    PWM_IN = '1;
    gap("dt5_rise_gap", 5);
    cyc("dt5_high", 1, 0, 0);
    cyc("dt5_high_hold", 1, 0, 0);
    PWM_IN = '0;
    gap("dt5_fall_gap", 5);
    cyc("dt5_low", 0, 1, 0);
    DEADTIME = 16'd0;
    PWM_IN = '1;
    cyc("dt0_high", 1, 0, 0);
    PWM_IN = '0;
    cyc("dt0_low", 0, 1, 0);
    PWM_IN = '1;
    cyc("dt0_high2", 1, 0, 0);
    PWM_IN = '0;
    cyc("dt0_low2", 0, 1, 0);
    DEADTIME = 16'd10;
    PWM_IN = '1;
    gap("short_pulse_gap", 4);
    PWM_IN = '0;
    cyc("short_abort_low", 0, 1, 0);
    cyc("short_low_hold", 0, 1, 0);
    DEADTIME = 16'd8;
    PWM_IN = '1;
    cyc("dt8_enter", 0, 0, 0);
    DEADTIME = 16'd2;
    gap("dt8_gap_kept", 7);
    cyc("dt8_high", 1, 0, 0);
    PWM_IN = '0;
    gap("dt2_fall_gap", 2);
    cyc("dt2_low", 0, 1, 0);
    DEADTIME = 16'd3;
    PWM_IN = '1;
    gap("dt3_rise_gap", 3);
    cyc("dt3_high", 1, 0, 0);
    PWM_IN = '0;
    cyc("fall_enter", 0, 0, 0);
    PWM_IN = '1;
    cyc("fall_abort_high", 1, 0, 0);
    FAULT = 1'b1;
    cyc("fault_off", 0, 0, 1);
    FAULT = 1'b0;
    cyc("fault_sticky", 0, 0, 1);
    cyc("fault_sticky2", 0, 0, 1);
    FAULT_CLR = 1'b1;
    cyc("fault_clr", 0, 0, 0);
    FAULT_CLR = 1'b0;
    cyc("recover_low_not_high", 0, 1, 0);
    cyc("recover_rise", 0, 0, 0);
    PWM_IN = '0;
    cyc("rise_abort_low", 0, 1, 0);
    FAULT = 1'b1; FAULT_CLR = 1'b1;
    cyc("set_beats_clr", 0, 0, 1);
    FAULT = 1'b0; FAULT_CLR = 1'b0;
    cyc("flag_held", 0, 0, 1);
    FAULT_CLR = 1'b1;
    cyc("flag_cleared", 0, 0, 0);
    FAULT_CLR = 1'b0;
    cyc("low_after_clr", 0, 1, 0);
    OUT_EN = 1'b0;
    cyc("out_en_off", 0, 0, 0);
    OUT_EN = 1'b1;
    cyc("out_en_low", 0, 1, 0);
    DEADTIME = 16'd5;
    PWM_IN = '1;
    cyc("pre_reset_gap", 0, 0, 0);
    RST = 1'b1;
    cyc("reset_mid_dt", 0, 0, 0);
    RST = 1'b0;
    cyc("post_reset_low", 0, 1, 0);
    cyc("post_reset_rise", 0, 0, 0);
    PWM_IN = '0;
    cyc("post_reset_abort", 0, 1, 0);
    DEADTIME = 16'd0;
    PWM_IN = 8'h02;
    cycv("chan_independent", 8'h02, 8'hFD, 1'b0);
    PWM_IN = 8'h81;
    cycv("chan_independent2", 8'h81, 8'h7E, 1'b0);
`ifdef PWM_DEADBAND_POLARITY_EN
    POL_INV = 8'h01;
    RST = 1'b1;
    cycv("pol_reset", 8'h01, 8'h01, 1'b0);
    RST = 1'b0; PWM_IN = '0;
    cycv("pol_low", 8'h01, 8'hFE, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pwm_deadband.md
PWM_DEADBAND -- requirements
Module: pwm_deadband

Interface
REQ-001 Parameter CH_NUM, default 8, number of PWM channels processed.
REQ-002 Parameter DT_W, default 16, width of the dead-time count.
REQ-003 CLK  input  1  single clock for all logic; every flop updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 PWM_IN  input  CH_NUM  raw PWM from the upstream PWM generator, one bit per channel, synchronous to CLK.
REQ-006 DEADTIME  input  DT_W  dead-time in CLK cycles, shared by all channels.
REQ-007 OUT_EN  input  1  global output enable; 0 forces all gate outputs inactive.
REQ-008 FAULT  input  1  synchronous active-high fault; forces all gate outputs inactive.
REQ-009 FAULT_CLR  input  1  single-cycle clear of the sticky fault flag.
REQ-010 PWM_H  output  CH_NUM  high-side gate drive per channel.
REQ-011 PWM_L  output  CH_NUM  low-side gate drive per channel.
REQ-012 FAULT_FLAG  output  1  sticky fault indicator.

Function
REQ-013 Each channel shall run an independent FSM with states OFF, LOW, DT_RISE, HIGH and DT_FALL.
REQ-014 PWM_H and PWM_L shall be driven directly from flops, with no combinational decode on the output path.
REQ-015 PWM_H[i] shall be 1 only in HIGH, PWM_L[i] shall be 1 only in LOW, and no state shall assert both.
REQ-016 LOW with PWM_IN=1 shall go to HIGH when DEADTIME==0; otherwise it shall go to DT_RISE and load cnt=DEADTIME-1.
REQ-017 HIGH with PWM_IN=0 shall go to LOW when DEADTIME==0; otherwise it shall go to DT_FALL and load cnt=DEADTIME-1.
REQ-018 In DT_RISE or DT_FALL, cnt==0 shall advance the FSM to HIGH or LOW respectively; otherwise cnt shall decrement.
REQ-019 Consequence: both outputs shall stay 0 for exactly DEADTIME cycles, and the output edge shall follow the sampled PWM_IN edge after DEADTIME+1 cycles.
REQ-020 DEADTIME shall be sampled only when a DT state is entered; changes mid-count shall not affect the count in progress.
REQ-021 Pulse abort: in DT_RISE with PWM_IN=0 the FSM shall return to LOW, and in DT_FALL with PWM_IN=1 it shall return to HIGH, both on the next edge with no output pulse emitted.
REQ-022 From any state, OUT_EN=0 or FAULT=1 shall force OFF on the next edge; this has priority over all other transitions.
REQ-023 OFF shall go to LOW only when OUT_EN=1, FAULT=0 and FAULT_FLAG=0; it shall never go directly to HIGH.
REQ-024 FAULT_FLAG shall set on the edge where FAULT=1 and shall clear on the edge where FAULT_CLR=1 and FAULT=0; if FAULT and FAULT_CLR are both 1, set wins.
REQ-025 The counter shall be DT_W bits wide with no wrap; DEADTIME equal to all-ones shall be legal and shall give 2^DT_W-1 dead cycles.

Reset
REQ-026 RST=1 shall put every channel in OFF with cnt=0.
REQ-027 RST=1 shall drive PWM_H=0, PWM_L=0 and FAULT_FLAG=0.
REQ-028 Reset asserted mid dead-time shall abandon the count; after RST deasserts, a channel shall reach LOW no earlier than one cycle later.

Configuration
REQ-029 Macro PWM_DEADBAND_POLARITY_EN shall, when defined, add input POL_INV[CH_NUM-1:0].
REQ-030 With the macro defined, PWM_H[i] and PWM_L[i] shall be registered as (internal value XOR POL_INV[i]), and their reset values shall equal POL_INV[i].
REQ-031 Without the macro, the POL_INV port shall be absent and the outputs shall be active-high.

Structure
REQ-032 A shared package pwm_pkg shall hold the FSM state enum (db_state_t) and the default CH_NUM and DT_W constants.
REQ-033 The per-channel FSM and counter shall be sub-module pwm_db_chan, instantiated CH_NUM times.
REQ-034 Fault and enable logic shall stay in pwm_deadband.

Verification
REQ-035 DEADTIME=5, OUT_EN=1, a PWM_IN[0] rise -> PWM_L[0] falls 1 cycle after the sampled rise and PWM_H[0] rises 6 cycles after it, with both outputs 0 for exactly 5 cycles; the falling edge is symmetric.
REQ-036 DEADTIME=0 -> H and L toggle 1 cycle after the PWM_IN edge with no overlap and no gap.
REQ-037 DEADTIME=10 and a 4-cycle PWM_IN high pulse -> PWM_H never asserts and PWM_L returns 1 cycle after PWM_IN falls.
REQ-038 FAULT pulsed during HIGH -> all outputs 0 on the next edge and FAULT_FLAG=1; OUT_EN=1 alone does not recover; FAULT_CLR then gives LOW 2 cycles later.
REQ-039 DEADTIME changed from 8 to 2 mid DT_RISE -> the current gap is still 8 cycles and the next gap is 2 cycles.
REQ-040 With PWM_DEADBAND_POLARITY_EN, POL_INV=8'h01, RST=1 -> PWM_H[0]=PWM_L[0]=1, and every other channel's PWM_H and PWM_L=0.
